// File: rtl/i2s_tx_if.sv
// i2s_tx_if: sample handshake and I2S pin bundle for the I2S transmitter.
interface i2s_tx_if #(
    parameter int b = 16
);
    logic [b-1:0] l;
    logic [b-1:0] r;
    logic in_valid;
    logic in_ready;
    logic sck;
    logic ws;
    logic sd;
    logic urun;
    modport master (output l, r, in_valid, input in_ready, sck, ws, sd, urun);
    modport slave (input l, r, in_valid, output in_ready, sck, ws, sd, urun);
endinterface

// File: rtl/i2s_tx.sv
// i2s_tx: Philips-format I2S master transmitter with a one-pair holding buffer.
module i2s_tx #(
    parameter int b   = 16,
    parameter int div = 4
) (
    input logic     clk,
    input logic     rst_n,
    i2s_tx_if.slave bus
);
    localparam int pw = $clog2(2 * div);
    localparam int kw = $clog2(2 * b);
    localparam logic [pw-1:0] p_end = pw'(2 * div - 1);
    localparam logic [pw-1:0] p_mid = pw'(div - 1);
    localparam logic [kw-1:0] k_end = kw'(2 * b - 1);
    localparam logic [kw-1:0] k_right = kw'(b);
    logic [pw-1:0] p;
    logic [kw-1:0] k, k_next;
    logic full, period_end, frame_end, accept;
    logic [b-1:0] hold_l, hold_r;
    logic [2*b-1:0] fr;
    logic sck, ws, sd, urun;
    always_comb begin
        period_end = p == p_end;
        frame_end  = period_end && k == k_end;
        accept     = bus.in_valid && !full;
        k_next     = frame_end ? '0 : k + kw'(1);
    end
    // fr rotates one bit per period so that after 2b-1 rotations its MSB is the
    // previous right LSB, which is exactly what slot 0 of the next frame sends.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p      <= '0;
            k      <= '0;
            full   <= 1'b0;
            hold_l <= '0;
            hold_r <= '0;
            fr     <= '0;
            sck    <= 1'b0;
            ws     <= 1'b0;
            sd     <= 1'b0;
            urun   <= 1'b0;
        end else begin
            p    <= period_end ? '0 : p + pw'(1);
            urun <= frame_end && !full;
            if (period_end) begin
                k   <= k_next;
                sck <= 1'b0;
                ws  <= k_next >= k_right;
                sd  <= fr[2*b-1];
                fr  <= frame_end ? (full ? {hold_l, hold_r} : '0) : {fr[2*b-2:0], fr[2*b-1]};
            end else if (p == p_mid) begin
                sck <= 1'b1;
            end
            if (accept) begin
                hold_l <= bus.l;
                hold_r <= bus.r;
                full   <= 1'b1;
            end else if (frame_end) begin
                full <= 1'b0;
            end
        end
    end
    assign bus.in_ready = !full;
    assign bus.sck      = sck;
    assign bus.ws       = ws;
    assign bus.sd       = sd;
    assign bus.urun     = urun;
endmodule
